// File: rtl/fpga_itf_pkg.sv
// Purpose : shared encodings for the ITF byte-transaction arbiter.
// Latency : n/a (constants only).
// Backpress: n/a.
// Contents: FSM state codes (3-bit), op codes, timeout read-data pattern.
package fpga_itf_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // Returned as read data when a transaction is aborted by timeout.
    localparam logic [7:0] ITF_ERR_DATA = 8'hFF;

endpackage

// File: rtl/fpga_rr_arb2.sv
// Purpose : 2-way round-robin winner pick; the last-served pointer lives in the parent.
// Latency : combinational.
// Backpress: none; the parent samples the result only when it can accept a request.
// Ports   : req_i[1:0] request levels, last_i last-served index,
//           win_o one-hot winner (0 when idle), any_o any request present.
module fpga_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] win_o,
    output logic       any_o
);

    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            // On a tie, serve whoever was not served last.
            2'b11:   win_o = last_i ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

    assign any_o = |req_i;

endmodule

// File: rtl/fpga_itf_arbiter.sv
// Purpose : grants one ITF byte transaction at a time to host-cmd or auto-poll, launches it,
//           waits for completion or timeout, returns rdata/err with a done pulse.
// Latency : gnt at T+1 after req, start pulse at T+2, done one cycle after completion.
// Backpress: requesters hold req/op/addr/data until gnt; req is sampled only in IDLE.
// Ports   : CLK/rst_n (sync active-low); req/wr/addr_i/wdata_i requester side (byte i = requester i);
//           gnt/done/rdata/err/busy status; addr_byte/data_byte/WriteByteStart/ReadByteStart
//           and itf_w_finish/itf_rd_valid/itf_rdata towards the ITF master.
module fpga_itf_arbiter
    import fpga_itf_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic        err,
    output logic        busy,
    output logic [7:0]  addr_byte,
    output logic [7:0]  data_byte,
    output logic        WriteByteStart,
    output logic        ReadByteStart,
    input  logic        itf_w_finish,
    input  logic        itf_rd_valid,
    input  logic [7:0]  itf_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       win_q, win_d;
    logic             ptr_q, ptr_d;
    logic             op_q, op_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             wstart_q, wstart_d;
    logic             rstart_q, rstart_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] arb_win;
    logic       arb_any;
    logic       sel;

    fpga_rr_arb2 u_rr (
        .req_i  (req),
        .last_i (ptr_q),
        .win_o  (arb_win),
        .any_o  (arb_any)
    );

    // Index of the currently granted requester.
    assign sel = win_q[1];

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        wstart_d = 1'b0;
        rstart_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    win_d   = arb_win;
                    // Registered here so the pulse lines up with the LATCH cycle.
                    gnt_d   = arb_win;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Requester fields are still held stable while gnt is visible.
                addr_d   = sel ? addr_i[15:8]  : addr_i[7:0];
                data_d   = sel ? wdata_i[15:8] : wdata_i[7:0];
                op_d     = wr[sel];
                ptr_d    = sel;
                err_d    = 1'b0;
                rdata_d  = 8'h00;
                wstart_d = (wr[sel] == OP_WR);
                rstart_d = (wr[sel] == OP_RD);
                state_d  = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion is checked before timeout so a coincident finish wins.
                if (op_q == OP_WR && itf_w_finish) begin
                    err_d   = 1'b0;
                    done_d  = win_q;
                    state_d = ST_DONE;
                end else if (op_q == OP_RD && itf_rd_valid) begin
                    err_d   = 1'b0;
                    rdata_d = itf_rdata;
                    done_d  = win_q;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = ITF_ERR_DATA;
                    done_d  = win_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= 2'b00;
            ptr_q    <= 1'b1;
            op_q     <= OP_RD;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            wstart_q <= 1'b0;
            rstart_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            wstart_q <= wstart_d;
            rstart_q <= rstart_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rdata          = rdata_q;
    assign err            = err_q;
    assign busy           = busy_q;
    assign addr_byte      = addr_q;
    assign data_byte      = data_q;
    assign WriteByteStart = wstart_q;
    assign ReadByteStart  = rstart_q;

endmodule

// File: doc/fpga_itf_arbiter.md
# fpga_itf_arbiter

Two-requester arbiter and sequencer for the single SPI/I2C byte-transaction master (the ITF). It sits between the host-command path (FIFO-driven TX control) and an on-FPGA auto-poll requester on one side, and the ITF master start/finish handshake on the other. It grants one byte transaction at a time, round-robin. It launches the write or read, waits for completion or timeout, and returns read data and status to the granted requester.

## Interface
Parameters:
- TIMEOUT_CYC, 4096: max CLK cycles spent in WAIT before a transaction is aborted; legal range 2..65535.

Ports:
- CLK  in  1  process clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  2  per-requester request level; bit i = requester i.
- wr  in  2  per-requester op: 1 = write, 0 = read.
- addr_i  in  16  packed addresses; [8i+7:8i] = requester i.
- wdata_i  in  16  packed write data; same packing.
- gnt  out  2  one-hot, one-cycle grant pulse.
- done  out  2  one-hot, one-cycle completion pulse.
- rdata  out  8  read data (or 8'hFF on timeout); valid while done is high, held until the next grant.
- err  out  1  timeout flag; valid with done, held until the next grant.
- busy  out  1  high in every state except IDLE.
- addr_byte  out  8  address to the ITF master.
- data_byte  out  8  write data to the ITF master.
- WriteByteStart  out  1  one-cycle write launch.
- ReadByteStart  out  1  one-cycle read launch.
- itf_w_finish  in  1  ITF write-complete pulse.
- itf_rd_valid  in  1  ITF read-data-valid pulse.
- itf_rdata  in  8  ITF read byte; valid with itf_rd_valid.

## Operation
- States: IDLE, LATCH, START, WAIT, DONE.
- IDLE:
  - req is sampled only here.
  - If any bit is set, pick a winner and go to LATCH.
- Arbitration:
  - A 1-bit last-served pointer decides ties. If both requesters request, the one not last served wins. A single requester always wins.
  - The pointer updates to the winner in LATCH.
  - Reset value of the pointer is 1, so requester 0 wins the first tie.
- LATCH:
  - Registers addr_byte, data_byte and op from the winner's fields.
  - gnt[winner] is high for exactly this cycle.
  - Clears err and rdata.
  - Goes to START.
- START:
  - WriteByteStart (op=1) or ReadByteStart (op=0) is high for exactly this cycle.
  - Clears the timeout counter and goes to WAIT.
- WAIT:
  - Write completes on itf_w_finish; read completes on itf_rd_valid. On a read completion, latch itf_rdata into rdata.
  - A completion of the wrong type is ignored.
  - Completion pulses arriving in LATCH or START are ignored.
  - The counter increments every WAIT cycle. On reaching TIMEOUT_CYC-1 with no completion: set err=1, rdata=8'hFF, go to DONE.
  - If completion and timeout occur in the same cycle, completion wins and err=0.
- DONE:
  - done[winner] is high for one cycle.
  - Return to IDLE.
- Requester rule:
  - Each requester holds req, wr, addr_i and wdata_i stable until it sees gnt, then may drop req.
  - A req still high when the arbiter returns to IDLE is treated as a new request.
- addr_byte and data_byte hold their values from LATCH until the next LATCH.
- Reset, including mid-transaction: all outputs, state, counter and pointer return to reset values. The in-flight transaction is abandoned and gets no done pulse.

## Timing
- Reset values: gnt=0, done=0, rdata=0, err=0, busy=0, addr_byte=0, data_byte=0, WriteByteStart=0, ReadByteStart=0; state IDLE; pointer 1.
- All outputs are registered.
- If req rises in cycle T (arbiter in IDLE):
  - gnt is high at T+1.
  - The start pulse is high at T+2.
  - WAIT begins at T+3.
- If the completion pulse is sampled in WAIT at cycle C:
  - done is high at C+1.
  - busy drops at C+2.
- Back-to-back requests: the earliest next gnt is 2 cycles after done (return to IDLE, then LATCH).
- Timeout: done is high TIMEOUT_CYC cycles after WAIT entry.
- Counter width: $clog2(TIMEOUT_CYC).

## Structure
- Shared package `fpga_itf_pkg` holds:
  - state encoding (3-bit);
  - OP_WR=1'b1 and OP_RD=1'b0;
  - ITF_ERR_DATA=8'hFF.
- One natural sub-module: `fpga_rr_arb2`, a 2-way round-robin picker. Inputs: req[1:0], last pointer. Outputs: one-hot winner, any. It is combinational; the pointer register stays in the parent.
- The FSM, counter and datapath registers live in `fpga_itf_arbiter`.

## Test plan
- Single write: req=01, wr=01, addr0=8'h12, wdata0=8'h34; itf_w_finish 5 cycles after the start pulse.
  - Expect gnt=01 at T+1, WriteByteStart at T+2 with addr_byte=8'h12 and data_byte=8'h34.
  - Expect done=01 one cycle after finish, err=0.
- Read: requester 1 reads addr 8'h40; itf_rd_valid with itf_rdata=8'hA5.
  - Expect ReadByteStart (not WriteByteStart), done=10, rdata=8'hA5.
- Contention: req=11 held continuously, both reads.
  - Expect grants in order 01, 10, 01, 10.
  - Expect each gnt 2 cycles after the previous done.
- Timeout: TIMEOUT_CYC=8, read with no ITF response.
  - Expect done 8 cycles after WAIT entry, err=1, rdata=8'hFF.
  - A completion injected during LATCH or START is ignored.
- Wrong-type completion and reset: a write receives itf_rd_valid only → no done before timeout.
  - Then rst_n=0 mid-WAIT for one cycle → all outputs 0, no done pulse.
  - Next req=11 grants requester 0 first.
